vga_console_ctrl: RTL and testbench

Terminal-style write controller for the TinyQV VGA text console. It accepts a stream of 9-bit cells from the host register interface into a small FIFO. It interprets printable characters and control codes, keeps a cursor, and sequences all writes into the 3×10 text buffer, including scroll-up and clear-screen sweeps. It sits between the peripheral's host write decode and the text buffer that the VGA scan-out reads.

---
 rtl/vga_console_pkg.sv | 23 ++
 rtl/vga_console_ctrl_fifo.sv | 50 +++++
 rtl/vga_console_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_vga_console_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_console_pkg.sv
// Shared constants, control codes and state encoding for the VGA text console writer.
package vga_console_pkg;

    localparam int NUM_ROWS  = 3;
    localparam int NUM_COLS  = 10;
    localparam int NUM_CHARS = NUM_ROWS * NUM_COLS;

    localparam logic [8:0] BLANK_CELL = 9'h020;

    localparam logic [6:0] CODE_BS        = 7'h08;
    localparam logic [6:0] CODE_LF        = 7'h0A;
    localparam logic [6:0] CODE_FF        = 7'h0C;
    localparam logic [6:0] CODE_CR        = 7'h0D;
    localparam logic [6:0] CODE_PRINT_MIN = 7'h20;
    localparam logic [6:0] CODE_PRINT_MAX = 7'h7E;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCROLL = 2'd1,
        ST_CLEAR  = 2'd2
    } state_e;

endpackage

// File: rtl/vga_console_ctrl_fifo.sv
// Synchronous FIFO for incoming console cells; push is ignored when full, pop when empty.
module console_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wptr_q, wptr_d, rptr_q, rptr_d;
    logic             do_push, do_pop;

    assign level   = wptr_q - rptr_q;
    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem_q[rptr_q[AW-1:0]];

    always_comb begin
        wptr_d = wptr_q + (AW+1)'(do_push);
        rptr_d = rptr_q + (AW+1)'(do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage holds data only, so it is left out of reset.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/vga_console_ctrl.sv
// Terminal-style writer: decodes queued cells, tracks the cursor and drives
// text buffer writes, including scroll-up and clear-screen sweeps.
module vga_console_ctrl #(
    parameter int NUM_ROWS   = vga_console_pkg::NUM_ROWS,
    parameter int NUM_COLS   = vga_console_pkg::NUM_COLS,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       char_valid,
    input  logic [8:0] char_data,
    output logic       char_ready,
    input  logic       clear_req,
    output logic       buf_we,
    output logic [4:0] buf_waddr,
    output logic [8:0] buf_wdata,
    output logic [4:0] buf_raddr,
    input  logic [8:0] buf_rdata,
    output logic [1:0] cursor_row,
    output logic [3:0] cursor_col,
    output logic       busy,
    output logic       done_irq
);

    import vga_console_pkg::*;

    localparam int N_CELLS = NUM_ROWS * NUM_COLS;
    localparam logic [4:0] LAST_IDX  = 5'(N_CELLS - 1);
    localparam logic [4:0] COPY_END  = 5'(N_CELLS - NUM_COLS);
    localparam logic [1:0] LAST_ROW  = 2'(NUM_ROWS - 1);
    localparam logic [3:0] LAST_COL  = 4'(NUM_COLS - 1);

    state_e     state_q, state_d;
    logic [4:0] idx_q, idx_d;
    logic [1:0] row_q, row_d;
    logic [3:0] col_q, col_d;
    logic       clr_pend_q, clr_pend_d;
    logic       busy_dly_q, busy_dly_d;
    logic       done_irq_q, done_irq_d;

    logic       fifo_pop, fifo_full, fifo_empty;
    logic [8:0] head;
    logic [$clog2(FIFO_DEPTH):0] fifo_level;
    logic [6:0] head_code;
    logic       is_print, ff_pop, enter_clear;
    logic [4:0] cursor_addr;

    console_fifo #(.WIDTH(9), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (char_valid),
        .wdata (char_data),
        .pop   (fifo_pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    assign head_code   = head[6:0];
    assign is_print    = (head_code >= CODE_PRINT_MIN) && (head_code <= CODE_PRINT_MAX);
    assign cursor_addr = 5'(int'(row_q) * NUM_COLS + int'(col_q));

    assign char_ready = ~fifo_full;
    assign busy       = (fifo_level != '0) | clr_pend_q | (state_q != ST_IDLE);
    assign done_irq   = done_irq_q;
    assign cursor_row = row_q;
    assign cursor_col = col_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            row_q      <= '0;
            col_q      <= '0;
            clr_pend_q <= 1'b0;
            busy_dly_q <= 1'b0;
            done_irq_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            row_q      <= row_d;
            col_q      <= col_d;
            clr_pend_q <= clr_pend_d;
            busy_dly_q <= busy_dly_d;
            done_irq_q <= done_irq_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        row_d       = row_q;
        col_d       = col_q;
        fifo_pop    = 1'b0;
        ff_pop      = 1'b0;
        enter_clear = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (clr_pend_q) begin
                    state_d     = ST_CLEAR;
                    idx_d       = '0;
                    enter_clear = 1'b1;
                end else if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    if (is_print) begin
                        if (col_q == LAST_COL) begin
                            col_d = '0;
                            if (row_q == LAST_ROW) begin
                                state_d = ST_SCROLL;
                                idx_d   = '0;
                            end else begin
                                row_d = row_q + 2'd1;
                            end
                        end else begin
                            col_d = col_q + 4'd1;
                        end
                    end else begin
                        case (head_code)
                            CODE_LF: begin
                                col_d = '0;
                                if (row_q == LAST_ROW) begin
                                    state_d = ST_SCROLL;
                                    idx_d   = '0;
                                end else begin
                                    row_d = row_q + 2'd1;
                                end
                            end
                            CODE_CR: col_d = '0;
                            CODE_BS: if (col_q != '0) col_d = col_q - 4'd1;
                            CODE_FF: ff_pop = 1'b1;
                            default: ;
                        endcase
                    end
                end
            end
            ST_SCROLL: begin
                idx_d = idx_q + 5'd1;
                if (idx_q == LAST_IDX) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                    row_d   = LAST_ROW;
                    col_d   = '0;
                end
            end
            ST_CLEAR: begin
                idx_d = idx_q + 5'd1;
                if (idx_q == LAST_IDX) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // A fresh request in the entry cycle wins so it is not lost.
        clr_pend_d = clear_req | ff_pop | (clr_pend_q & ~enter_clear);
        busy_dly_d = busy;
        done_irq_d = busy_dly_q & ~busy;
    end

    always_comb begin
        buf_we    = 1'b0;
        buf_waddr = '0;
        buf_wdata = '0;
        buf_raddr = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (!clr_pend_q && !fifo_empty && is_print) begin
                    buf_we    = 1'b1;
                    buf_waddr = cursor_addr;
                    buf_wdata = head;
                end
            end
            ST_SCROLL: begin
                buf_we    = 1'b1;
                buf_waddr = idx_q;
                if (idx_q < COPY_END) begin
                    buf_raddr = idx_q + 5'(NUM_COLS);
                    buf_wdata = buf_rdata;
                end else begin
                    buf_wdata = BLANK_CELL;
                end
            end
            ST_CLEAR: begin
                buf_we    = 1'b1;
                buf_waddr = idx_q;
                buf_wdata = BLANK_CELL;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_vga_console_ctrl.sv
// Scoreboard bench for vga_console_ctrl: stimulus queues expected buffer writes,
// a negedge monitor pops and compares every write the DUT issues.
module tb_vga_console_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       char_valid;
    logic [8:0] char_data;
    logic       char_ready;
    logic       clear_req;
    logic       buf_we;
    logic [4:0] buf_waddr;
    logic [8:0] buf_wdata;
    logic [4:0] buf_raddr;
    logic [8:0] buf_rdata;
    logic [1:0] cursor_row;
    logic [3:0] cursor_col;
    logic       busy;
    logic       done_irq;

    vga_console_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .char_valid (char_valid),
        .char_data  (char_data),
        .char_ready (char_ready),
        .clear_req  (clear_req),
        .buf_we     (buf_we),
        .buf_waddr  (buf_waddr),
        .buf_wdata  (buf_wdata),
        .buf_raddr  (buf_raddr),
        .buf_rdata  (buf_rdata),
        .cursor_row (cursor_row),
        .cursor_col (cursor_col),
        .busy       (busy),
        .done_irq   (done_irq)
    );

    always #5 clk = ~clk;

    // Text buffer stand-in with combinational read port.
    logic [8:0] tbuf [30];
    always @(posedge clk) if (buf_we) tbuf[buf_waddr] <= buf_wdata;
    assign buf_rdata = tbuf[buf_raddr];

    typedef struct packed {
        logic [4:0] a;
        logic [8:0] d;
    } wr_t;

    wr_t        exp_q[$];
    wr_t        mon_e;
    int         checks = 0;
    int         failures = 0;
    int         wr_cnt = 0;
    int         done_cnt = 0;
    int         exp_row = 0;
    int         exp_col = 0;
    logic [8:0] exp_scr [30];

    always @(negedge clk) begin
        if (rst_n === 1'b1 && buf_we === 1'b1) begin
            wr_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write got addr=%0d data=%h required none", buf_waddr, buf_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                if (buf_waddr !== mon_e.a || buf_wdata !== mon_e.d) begin
                    failures++;
                    $display("FAIL buf_write got addr=%0d data=%h required addr=%0d data=%h",
                             buf_waddr, buf_wdata, mon_e.a, mon_e.d);
                end
            end
        end
        if (rst_n === 1'b1 && done_irq === 1'b1) done_cnt++;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            failures++;
            $display("FAIL %s got=%0h required=%0h", name, got, req);
        end
    endtask

    task automatic push_exp(input int a, input logic [8:0] d);
        wr_t e;
        e.a = 5'(a);
        e.d = d;
        exp_q.push_back(e);
    endtask

    task automatic model_clear();
        for (int i = 0; i < 30; i++) begin
            push_exp(i, 9'h020);
            exp_scr[i] = 9'h020;
        end
        exp_row = 0;
        exp_col = 0;
    endtask

    task automatic model_scroll();
        for (int i = 0; i < 30; i++) begin
            if (i < 20) exp_scr[i] = exp_scr[i+10];
            else        exp_scr[i] = 9'h020;
            push_exp(i, exp_scr[i]);
        end
        exp_row = 2;
        exp_col = 0;
    endtask

    task automatic model_char(input logic [8:0] d);
        logic [6:0] c;
        c = d[6:0];
        if (c >= 7'h20 && c <= 7'h7E) begin
            push_exp(exp_row*10 + exp_col, d);
            exp_scr[exp_row*10 + exp_col] = d;
            if (exp_col == 9) begin
                exp_col = 0;
                if (exp_row == 2) model_scroll();
                else exp_row++;
            end else begin
                exp_col++;
            end
        end else if (c == 7'h0A) begin
            exp_col = 0;
            if (exp_row == 2) model_scroll();
            else exp_row++;
        end else if (c == 7'h0D) begin
            exp_col = 0;
        end else if (c == 7'h08) begin
            if (exp_col > 0) exp_col--;
        end else if (c == 7'h0C) begin
            model_clear();
        end
    endtask

    // Raw handshake: hold the cell until the edge where char_ready is high.
    task automatic push_raw(input logic [8:0] d);
        int n;
        n = 0;
        char_valid = 1'b1;
        char_data  = d;
        while (!char_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!char_ready) begin
            checks++;
            failures++;
            $display("FAIL push_timeout got ready=0 required ready=1");
        end else begin
            @(posedge clk); #1;
        end
        char_valid = 1'b0;
    endtask

    task automatic send(input logic [8:0] d);
        model_char(d);
        push_raw(d);
    endtask

    task automatic pulse_clear();
        model_clear();
        clear_req = 1'b1;
        @(posedge clk); #1;
        clear_req = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        if (busy) begin
            checks++;
            failures++;
            $display("FAIL idle_timeout got busy=1 required busy=0");
        end
        repeat (2) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic chk_cursor(input string name, input int r, input int c);
        chk({name, "_row"}, 32'(cursor_row), 32'(r));
        chk({name, "_col"}, 32'(cursor_col), 32'(c));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, w0, n;
        for (int i = 0; i < 30; i++) exp_scr[i] = 9'h020;
        rst_n      = 1'b0;
        char_valid = 1'b0;
        char_data  = '0;
        clear_req  = 1'b0;
        #1;
        chk("rst_buf_we", 32'(buf_we), 0);
        chk("rst_waddr", 32'(buf_waddr), 0);
        chk("rst_wdata", 32'(buf_wdata), 0);
        chk("rst_raddr", 32'(buf_raddr), 0);
        chk_cursor("rst_cursor", 0, 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done_irq), 0);
        chk("rst_ready", 32'(char_ready), 1);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Establish known buffer contents.
        pulse_clear();
        wait_idle();
        chk_cursor("init_clear", 0, 0);

        // "HI" at addresses 0 and 1, one done pulse.
        d0 = done_cnt;
        send(9'h048);
        send(9'h049);
        wait_idle();
        chk_cursor("hi", 0, 2);
        chk("hi_done_pulses", 32'(done_cnt - d0), 1);

        // 30 colored 'A' cells from column 0: fills the screen then scrolls.
        send(9'h00D);
        w0 = wr_cnt;
        for (int i = 0; i < 30; i++) send(9'h0C1);
        wait_idle();
        chk_cursor("fill_scroll", 2, 0);
        chk("fill_scroll_writes", 32'(wr_cnt - w0), 60);

        // Control codes.
        send(9'h00C);
        send(9'h00A);
        for (int i = 0; i < 5; i++) send(9'h061 + 9'(i));
        wait_idle();
        chk_cursor("at_1_5", 1, 5);
        send(9'h10D);
        wait_idle();
        chk_cursor("cr", 1, 0);
        send(9'h008);
        wait_idle();
        chk_cursor("bs_col0", 1, 0);
        send(9'h00A);
        wait_idle();
        chk_cursor("lf", 2, 0);
        send(9'h00A);
        wait_idle();
        chk_cursor("lf_scroll", 2, 0);
        send(9'h078);
        send(9'h079);
        send(9'h008);
        wait_idle();
        chk_cursor("bs", 2, 1);
        send(9'h01B);
        wait_idle();
        chk_cursor("discard", 2, 1);

        // Clear requested mid-scroll, then a queued cell.
        send(9'h00A);
        repeat (5) @(posedge clk);
        #1;
        pulse_clear();
        send(9'h151);
        wait_idle();
        chk_cursor("clear_mid_scroll", 0, 1);

        // FIFO back-pressure during a scroll.
        send(9'h00A);
        send(9'h00A);
        send(9'h00A);
        for (int i = 0; i < 4; i++) send(9'h031 + 9'(i));
        chk("ready_when_full", 32'(char_ready), 0);
        send(9'h035);
        wait_idle();
        chk_cursor("backpressure", 2, 5);

        // Reset in the middle of a clear sweep.
        pulse_clear();
        n = 0;
        while (!(buf_we && buf_waddr == 5'd12 && buf_wdata == 9'h020) && n < 100) begin
            @(posedge clk); #2;
            n++;
        end
        chk("clear_reached_12", 32'(buf_waddr), 12);
        #1 rst_n = 1'b0;
        #1;
        exp_q.delete();
        exp_row = 0;
        exp_col = 0;
        chk("abort_buf_we", 32'(buf_we), 0);
        chk("abort_waddr", 32'(buf_waddr), 0);
        chk("abort_wdata", 32'(buf_wdata), 0);
        chk_cursor("abort_cursor", 0, 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_ready", 32'(char_ready), 1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_busy", 32'(busy), 0);
        chk("post_rst_done", 32'(done_irq), 0);
        send(9'h05A);
        wait_idle();
        chk_cursor("post_rst", 0, 1);

        chk("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
